rdagent_collector: RTL and testbench

Read-side collector for one read agent of the multi-bank RAM. It accepts read requests, broadcasts the address to every write-agent bank and to the accounter, and captures the accounter's bank select in the issue cycle. It delays that select to match the bank read latency, muxes the returned row from the selected bank, and delivers it through a credit-protected response FIFO with valid/ready flow control. One instance sits downstream of the accounter for each read agent.

---
 rtl/rdagent_collector_pkg.sv | 9 +
 rtl/rdagent_collector_if.sv | 25 ++
 rtl/rdagent_collector_fifo.sv | 65 ++++++
 rtl/rdagent_collector.sv | 111 +++++++++++
 tb/tb_rdagent_collector.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rdagent_collector_pkg.sv
// Shared definitions for the multi-bank RAM read path.
// sel_width: bank-select width for a given agent count, never below 1 bit.
package meduram_pkg;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdagent_collector_if.sv
// Read request / read response handshake bundle for one read agent.
//   rdreq_*  : request channel (valid/ready, address)
//   rdresp_* : response channel (valid/ready, data)
// master = requester side, slave = collector side.
interface rdagent_collector_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  rdreq_valid;
  logic                  rdreq_ready;
  logic [ADDR_WIDTH-1:0] rdreq_addr;
  logic                  rdresp_valid;
  logic                  rdresp_ready;
  logic [DATA_WIDTH-1:0] rdresp_data;

  modport master (
    output rdreq_valid, rdreq_addr, rdresp_ready,
    input  rdreq_ready, rdresp_valid, rdresp_data
  );

  modport slave (
    input  rdreq_valid, rdreq_addr, rdresp_ready,
    output rdreq_ready, rdresp_valid, rdresp_data
  );
endinterface

// File: rtl/rdagent_collector_fifo.sv
// rdresp_fifo: synchronous FIFO with registered full/empty/dout.
//   push/din : write side      pop : read side (ignored while empty)
//   full/empty/dout : registered status and head-of-queue data
module rdresp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;

  assign pop_ok = pop & ~empty_q;

  always_comb begin
    wptr_d  = push   ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    // Registered head: if the slot being written becomes the head, forward din.
    if (push && (wptr_q == rptr_d)) begin
      dout_d = din;
    end else begin
      dout_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign dout  = dout_q;
endmodule

// File: rtl/rdagent_collector.sv
// Read-side collector for one read agent of the multi-bank RAM.
//   aclk/aresetn  : clock, async active-low reset
//   rd            : request/response handshake (slave modport)
//   bank_rden/bank_rdaddr : broadcast read to all banks and the accounter
//   acc_rdselect  : accounter's owning-bank select for bank_rdaddr
//   bank_rddata   : concatenated bank outputs, bank i at [DATA_WIDTH*i +: DATA_WIDTH]
module rdagent_collector
  import meduram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NB_WRAGENT   = 2,
  parameter int unsigned SELECT_WIDTH = sel_width(NB_WRAGENT),
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  rdagent_collector_if.slave               rd,
  output logic                             bank_rden,
  output logic [ADDR_WIDTH-1:0]            bank_rdaddr,
  input  logic [SELECT_WIDTH-1:0]          acc_rdselect,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                    valid;
    logic [SELECT_WIDTH-1:0] sel;
  } rdpipe_t;

  if (RD_LATENCY < 1) begin : g_chk_lat
    $error("RD_LATENCY must be at least 1");
  end
  if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_chk_depth
    $error("FIFO_DEPTH must be at least RD_LATENCY+1");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_pow2
    $error("FIFO_DEPTH must be a power of 2");
  end

  logic [CW-1:0]                credits_q, credits_d;
  rdpipe_t [RD_LATENCY-1:0]     pipe_q, pipe_d;
  rdpipe_t                      tail;
  logic                         issue, pop, push;
  logic [DATA_WIDTH-1:0]        push_data, fifo_dout;
  logic                         fifo_full, fifo_empty;

  assign rd.rdreq_ready = (credits_q != '0);
  assign issue          = rd.rdreq_valid & rd.rdreq_ready;
  assign pop            = ~fifo_empty & rd.rdresp_ready;
  assign bank_rden      = issue;
  assign bank_rdaddr    = rd.rdreq_addr;

  // Credits = free FIFO slots minus reads in flight.
  always_comb begin
    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - 1'b1;
    end else if (pop && !issue) begin
      credits_d = credits_q + 1'b1;
    end
  end

  always_comb begin
    pipe_d[0] = '{valid: issue, sel: acc_rdselect};
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign tail = pipe_q[RD_LATENCY-1];
  assign push = tail.valid;

  // Out-of-range selects match no bank and return zero.
  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
      if (tail.sel == SELECT_WIDTH'(i)) begin
        push_data = bank_rddata[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      credits_q <= CW'(FIFO_DEPTH);
      pipe_q    <= '0;
    end else begin
      credits_q <= credits_d;
      pipe_q    <= pipe_d;
    end
  end

  rdresp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push & ~fifo_full),
    .pop   (pop),
    .din   (push_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign rd.rdresp_valid = ~fifo_empty;
  assign rd.rdresp_data  = fifo_dout;
endmodule

// File: tb/tb_rdagent_collector.sv
// Bench: instance u[0] (RD_LATENCY=1) takes directed tests, u[1] (RD_LATENCY=3)
// takes a random run. Bank/accounter contents live in shared arrays; the
// expected response is the owner bank's value at the time the request is taken.
module tb_rdagent_collector;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = 2;
  localparam int unsigned SW    = 1;
  localparam int unsigned DEPTH = 4;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [DW-1:0] mem [NB][256];
  logic [SW-1:0] acc_sel [256];

  int errors = 0;
  int checks = 0;

  logic          req_valid   [2];
  logic [AW-1:0] req_addr    [2];
  logic          resp_ready  [2];
  logic          req_ready_o [2];
  logic          resp_valid_o[2];
  logic          rden_o      [2];
  logic [DW-1:0] resp_data_o [2];
  int            acc_cnt     [2];
  int            pop_cnt     [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    rdagent_collector_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          bank_rden;
    logic [AW-1:0] bank_rdaddr;
    logic [SW-1:0] acc_rdselect;
    logic [NB*DW-1:0] bank_rddata;
    logic [NB*DW-1:0] dly [LAT];
    logic [DW-1:0] expq [$];
    int            outstanding = 0;

    assign bus.rdreq_valid  = req_valid[g];
    assign bus.rdreq_addr   = req_addr[g];
    assign bus.rdresp_ready = resp_ready[g];
    assign req_ready_o[g]   = bus.rdreq_ready;
    assign resp_valid_o[g]  = bus.rdresp_valid;
    assign resp_data_o[g]   = bus.rdresp_data;
    assign rden_o[g]        = bank_rden;

    // Accounter: combinational owner lookup. Banks: read-before-write, LAT cycles.
    assign acc_rdselect = acc_sel[bank_rdaddr];
    assign bank_rddata  = dly[LAT-1];
    always @(posedge aclk) begin
      dly[0] <= {mem[1][bank_rdaddr], mem[0][bank_rdaddr]};
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end

    rdagent_collector #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .NB_WRAGENT   (NB),
      .SELECT_WIDTH (SW),
      .RD_LATENCY   (LAT),
      .FIFO_DEPTH   (DEPTH)
    ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .rd           (bus),
      .bank_rden    (bank_rden),
      .bank_rdaddr  (bank_rdaddr),
      .acc_rdselect (acc_rdselect),
      .bank_rddata  (bank_rddata)
    );

    always @(negedge aclk) begin
      if (!aresetn) begin
        expq.delete();
        outstanding = 0;
      end else begin
        check($sformatf("u%0d_rdreq_ready", g), req_ready_o[g], outstanding < DEPTH);
        if (resp_valid_o[g] && resp_ready[g]) begin
          pop_cnt[g]++;
          if (expq.size() == 0) begin
            check($sformatf("u%0d_unexpected_resp", g), resp_valid_o[g], 1'b0);
          end else begin
            check($sformatf("u%0d_resp_data", g), resp_data_o[g], expq.pop_front());
            outstanding--;
          end
        end
        if (req_valid[g] && req_ready_o[g]) begin
          expq.push_back(mem[acc_sel[req_addr[g]]][req_addr[g]]);
          outstanding++;
          acc_cnt[g]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int a0, p0;
    logic [AW-1:0] wa;
    logic [SW-1:0] wo;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_addr[g] = '0; resp_ready[g] = 1'b0;
      acc_cnt[g] = 0; pop_cnt[g] = 0;
    end
    for (int a = 0; a < 256; a++) begin
      acc_sel[a] = SW'($urandom_range(0, 1));
      mem[0][a]  = $urandom;
      mem[1][a]  = $urandom;
    end

    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("u%0d_rst_rdreq_ready", g), req_ready_o[g], 1'b1);
      check($sformatf("u%0d_rst_rdresp_valid", g), resp_valid_o[g], 1'b0);
      check($sformatf("u%0d_rst_rdresp_data", g), resp_data_o[g], '0);
      check($sformatf("u%0d_rst_bank_rden", g), rden_o[g], 1'b0);
    end
    aresetn = 1'b1;
    step();

    // Single read: owner is bank 1.
    mem[1][8'h10] = 32'hCAFE0001;
    mem[0][8'h10] = 32'hDEAD0000;
    acc_sel[8'h10] = 1'b1;
    req_addr[0] = 8'h10; req_valid[0] = 1'b1;
    #1 check("single_bank_rden", rden_o[0], 1'b1);
    step();
    req_valid[0] = 1'b0;
    check("single_valid_T1", resp_valid_o[0], 1'b0);
    step();
    check("single_valid_T2", resp_valid_o[0], 1'b1);
    check("single_data", resp_data_o[0], 32'hCAFE0001);
    resp_ready[0] = 1'b1;
    step();
    check("single_drained", resp_valid_o[0], 1'b0);

    // Streaming 16 reads with alternating owner.
    for (int a = 0; a < 16; a++) acc_sel[a] = SW'(a % 2);
    p0 = pop_cnt[0];
    for (int i = 0; i < 16; i++) begin
      req_addr[0] = AW'(i); req_valid[0] = 1'b1;
      check("stream_ready", req_ready_o[0], 1'b1);
      step();
    end
    req_valid[0] = 1'b0;
    repeat (2) step();
    check("stream_pops", pop_cnt[0] - p0, 16);

    // Back-pressure: only DEPTH accepted, then one more per pop.
    resp_ready[0] = 1'b0;
    a0 = acc_cnt[0];
    repeat (8) begin
      req_addr[0] = AW'($urandom); req_valid[0] = 1'b1;
      step();
    end
    check("bp_accepted", acc_cnt[0] - a0, DEPTH);
    check("bp_ready_low", req_ready_o[0], 1'b0);
    a0 = acc_cnt[0];
    resp_ready[0] = 1'b1;
    step();
    resp_ready[0] = 1'b0;
    repeat (5) step();
    check("bp_one_more", acc_cnt[0] - a0, 1);
    check("bp_ready_low_again", req_ready_o[0], 1'b0);
    req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    repeat (8) step();

    // Same-cycle write and read: old owner's value, then the new owner's.
    acc_sel[8'h20] = 1'b0;
    mem[0][8'h20]  = 32'h00000A0D;
    mem[1][8'h20]  = 32'h11111111;
    req_addr[0] = 8'h20; req_valid[0] = 1'b1;
    step();
    mem[1][8'h20]  = 32'h22222222;
    acc_sel[8'h20] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    check("rw_old_valid", resp_valid_o[0], 1'b1);
    check("rw_old_data", resp_data_o[0], 32'h00000A0D);
    step();
    check("rw_new_data", resp_data_o[0], 32'h22222222);
    repeat (3) step();

    // Reset with three reads in flight.
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    repeat (3) begin
      req_addr[0] = AW'($urandom);
      step();
    end
    req_valid[0] = 1'b0;
    aresetn = 1'b0;
    #1;
    check("rst_mid_valid", resp_valid_o[0], 1'b0);
    check("rst_mid_ready", req_ready_o[0], 1'b1);
    repeat (2) step();
    aresetn = 1'b1;
    resp_ready[0] = 1'b1;
    repeat (6) begin
      step();
      check("post_rst_no_stale", resp_valid_o[0], 1'b0);
    end

    // Random traffic on the RD_LATENCY=3 instance with concurrent writes.
    for (int c = 0; c < 1000; c++) begin
      req_valid[1]  = 1'($urandom_range(0, 1));
      req_addr[1]   = AW'($urandom);
      resp_ready[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3) begin
        wa = AW'($urandom);
        wo = SW'($urandom_range(0, 1));
        mem[wo][wa] = $urandom;
        acc_sel[wa] = wo;
      end
      step();
    end
    req_valid[1] = 1'b0; resp_ready[1] = 1'b1;
    repeat (20) step();
    check("rand_drained", u[1].expq.size(), 0);
    check("rand_no_loss", pop_cnt[1], acc_cnt[1]);
    check("rand_activity", acc_cnt[1] > 100, 1'b1);
    check("u0_drained", u[0].expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
